alu_result_uart_tx: RTL and testbench
=====================================

// Module: alu_result_uart_tx
// PURPOSE
//  Return path from ALU to host. Captures the ALU result when the operand/opcode
//  assembler pulses data-ready, then sends a 3-byte response frame to the UART
//  transmitter: [HEADER][RESULT][FLAGS]. Each byte uses a start/busy handshake.
//  Sits between the ALU output and the UART TX; the TX busy line is shared with
//  the upstream assembler.
// PARAMETERS
//  NB_DATA      8      width of ALU result and UART byte
//  HEADER       8'hA5  first byte of every response frame
//  ACK_TIMEOUT  16     cycles to wait for i_tx_busy to rise before re-pulsing start
// PORTS
//  i_clk         in   1        system clock, all logic on rising edge
//  i_reset_n     in   1        asynchronous, active-low reset
//  i_data_ready  in   1        1-cycle pulse: i_result/i_carry valid this cycle
//  i_result      in   NB_DATA  ALU result
//  i_carry       in   1        ALU carry/borrow out
//  i_tx_busy     in   1        UART TX is shifting a byte
//  o_tx_data     out  NB_DATA  byte to transmit, registered
//  o_tx_start    out  1        1-cycle start pulse to UART TX, registered
//  o_busy        out  1        high whenever state != IDLE
//  o_overrun     out  1        sticky: a request was dropped while busy
// BEHAVIOUR
//  Reset (async, i_reset_n=0): state=IDLE, byte_idx=0, timeout cnt=0, captured regs=0;
//   o_tx_data=0, o_tx_start=0, o_busy=0, o_overrun=0. Reset mid-frame aborts the
//   frame; nothing resumes after release.
//  FSM: IDLE -> START -> WAIT_ACK -> WAIT_DONE -> (START | IDLE).
//  IDLE: on i_data_ready=1 at edge N, latch res=i_result and
//   flags={{NB_DATA-2{1'b0}}, i_carry, (i_result==0)}; set byte_idx=0 -> START.
//  START: if i_tx_busy=0, at the next edge load o_tx_data = HEADER/res/flags
//   (idx 0/1/2), pulse o_tx_start=1 for exactly one cycle, clear cnt -> WAIT_ACK.
//   If i_tx_busy=1, hold in START. First start pulse is high in cycle N+2 when TX is idle.
//  WAIT_ACK: i_tx_busy=1 -> WAIT_DONE. Otherwise cnt++; when cnt reaches
//   ACK_TIMEOUT-1 -> START (same byte is re-sent, byte_idx unchanged).
//  WAIT_DONE: on i_tx_busy=0: if byte_idx==2 -> IDLE, else byte_idx++ -> START.
//  o_tx_data holds its value from the start pulse until the next byte is loaded.
//   It is never changed while i_tx_busy=1.
//  Requests are accepted only in IDLE. i_data_ready=1 in any other state,
//   including the final WAIT_DONE->IDLE cycle, is dropped and sets o_overrun=1.
//   o_overrun is cleared only by reset.
//  Captured res/flags are unaffected by i_result changes after capture.
//  Zero flag is computed on the full NB_DATA result; bits above flags[1] are 0.
//  o_tx_start is never asserted in the same cycle as i_tx_busy=1 was sampled in START.
// TESTING
//  Reset: hold i_reset_n=0 with random inputs -> all outputs 0, o_busy=0.
//  i_result=8'h3C, i_carry=1, TX model busy 10 cycles/byte -> bytes A5,3C,02;
//   exactly 3 start pulses; o_busy drops after the 3rd busy falls.
//  i_result=8'h00, i_carry=0 -> bytes A5,00,01.
//  Second i_data_ready (8'hFF) during byte 1 -> frame stays A5,3C,02;
//   o_overrun=1 and stays 1; no fourth byte.
//  TX model ignores the first start (busy never rises) -> start re-pulsed 16 cycles
//   later with o_tx_data=A5; frame completes normally.
//  Assert i_reset_n=0 after byte 2 starts, then release; new request 8'h11 ->
//   frame A5,11,00 from byte 0.

Source files
------------

// File: rtl/alu_result_uart_tx.sv
`timescale 1ns/1ps
// alu_result_uart_tx
//   Return path from the ALU to the host. When the operand/opcode assembler
//   pulses i_data_ready, the ALU result and carry are captured and a 3-byte
//   frame [HEADER][RESULT][FLAGS] is sent to the UART TX, one byte per
//   start/busy handshake. FLAGS = {0..0, carry, zero}.
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   IDLE      | waiting for i_data_ready; the only state that accepts work
//   START     | waiting for TX idle, then load byte and pulse o_tx_start
//   WAIT_ACK  | waiting for TX to raise busy; re-send the byte on timeout
//   WAIT_DONE | waiting for TX to finish; advance byte or return to IDLE
//
// Ports
//   i_clk        system clock, rising edge
//   i_reset_n    asynchronous active-low reset
//   i_data_ready 1-cycle pulse, i_result/i_carry valid
//   i_result     ALU result
//   i_carry      ALU carry/borrow out
//   i_tx_busy    UART TX shifting a byte
//   o_tx_data    byte to transmit (registered, held until the next load)
//   o_tx_start   1-cycle start pulse (registered)
//   o_busy       high whenever a frame is in progress
//   o_overrun    sticky: a request arrived while busy and was dropped
module alu_result_uart_tx #(
  parameter int                 NB_DATA     = 8,
  parameter logic [NB_DATA-1:0] HEADER      = 8'hA5,
  parameter int                 ACK_TIMEOUT = 16
) (
  input  logic               i_clk,
  input  logic               i_reset_n,
  input  logic               i_data_ready,
  input  logic [NB_DATA-1:0] i_result,
  input  logic               i_carry,
  input  logic               i_tx_busy,
  output logic [NB_DATA-1:0] o_tx_data,
  output logic               o_tx_start,
  output logic               o_busy,
  output logic               o_overrun
);

  localparam int CNT_W = $clog2(ACK_TIMEOUT) + 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_WAIT_ACK,
    ST_WAIT_DONE
  } state_t;

  state_t               state_q, state_d;
  logic [NB_DATA-1:0]   res_q;
  logic [NB_DATA-1:0]   flags_q;
  logic [1:0]           idx_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [CNT_W-1:0]     cnt_plus;
  logic [NB_DATA-1:0]   tx_data_q;
  logic                 tx_start_q;
  logic                 overrun_q;
  logic [NB_DATA-1:0]   byte_sel;

  logic capture;
  logic load_byte;
  logic cnt_inc;
  logic idx_inc;

  assign cnt_plus = cnt_q + CNT_W'(1);

  always_comb begin
    case (idx_q)
      2'd0:    byte_sel = HEADER;
      2'd1:    byte_sel = res_q;
      default: byte_sel = flags_q;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    capture   = 1'b0;
    load_byte = 1'b0;
    cnt_inc   = 1'b0;
    idx_inc   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (i_data_ready) begin
          capture = 1'b1;
          state_d = ST_START;
        end
      end
      ST_START: begin
        if (!i_tx_busy) begin
          load_byte = 1'b1;
          state_d   = ST_WAIT_ACK;
        end
      end
      ST_WAIT_ACK: begin
        if (i_tx_busy) begin
          state_d = ST_WAIT_DONE;
        end else begin
          cnt_inc = 1'b1;
          // Timeout fires the cycle the count reaches ACK_TIMEOUT-1,
          // giving a re-pulse ACK_TIMEOUT cycles after the original start.
          if (cnt_plus == CNT_W'(ACK_TIMEOUT - 1)) begin
            state_d = ST_START;
          end
        end
      end
      ST_WAIT_DONE: begin
        if (!i_tx_busy) begin
          if (idx_q == 2'd2) begin
            state_d = ST_IDLE;
          end else begin
            idx_inc = 1'b1;
            state_d = ST_START;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q    <= ST_IDLE;
      res_q      <= '0;
      flags_q    <= '0;
      idx_q      <= '0;
      cnt_q      <= '0;
      tx_data_q  <= '0;
      tx_start_q <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      tx_start_q <= load_byte;
      if (capture) begin
        res_q   <= i_result;
        flags_q <= {{(NB_DATA-2){1'b0}}, i_carry, (i_result == '0)};
        idx_q   <= '0;
      end
      if (idx_inc) begin
        idx_q <= idx_q + 2'd1;
      end
      if (load_byte) begin
        tx_data_q <= byte_sel;
        cnt_q     <= '0;
      end else if (cnt_inc) begin
        cnt_q <= cnt_plus;
      end
      if (i_data_ready && (state_q != ST_IDLE)) begin
        overrun_q <= 1'b1;
      end
    end
  end

  assign o_tx_data  = tx_data_q;
  assign o_tx_start = tx_start_q;
  assign o_busy     = (state_q != ST_IDLE);
  assign o_overrun  = overrun_q;

endmodule

// File: tb/tb_alu_result_uart_tx.sv
`timescale 1ns/1ps
module tb_alu_result_uart_tx;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       dr = 1'b0;
  logic [7:0] res = 8'h00;
  logic       carry = 1'b0;
  logic       busy_m = 1'b0;
  logic       rand_mode = 1'b0;
  logic       rand_busy = 1'b0;
  logic       tx_busy;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       busy;
  logic       overrun;

  assign tx_busy = rand_mode ? rand_busy : busy_m;

  int total = 0;
  int nbad = 0;
  int cyc = 0;
  int start_cnt = 0;
  int ignore_cnt = 0;
  int busy_len = 10;
  logic [7:0] exp_q[$];
  int start_times[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  alu_result_uart_tx dut (
    .i_clk        (clk),
    .i_reset_n    (rst_n),
    .i_data_ready (dr),
    .i_result     (res),
    .i_carry      (carry),
    .i_tx_busy    (tx_busy),
    .o_tx_data    (tx_data),
    .o_tx_start   (tx_start),
    .o_busy       (busy),
    .o_overrun    (overrun)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      nbad++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", nm, act, expv, $time);
    end
  endtask

  // Reference: flags byte carries the carry in bit 1 and zero in bit 0.
  function automatic logic [7:0] flags_of(input logic [7:0] r, input logic c);
    int v;
    v = (c ? 2 : 0) + ((r == 8'd0) ? 1 : 0);
    return 8'(v);
  endfunction

  // Scoreboard monitor: every start pulse consumes one expected byte.
  initial begin
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (rst_n && tx_start) begin
        start_cnt++;
        start_times.push_back(cyc);
        if (exp_q.size() == 0) begin
          total++;
          nbad++;
          $display("FAIL extra_start actual=%0h expected=none", tx_data);
        end else begin
          e = exp_q.pop_front();
          chk("tx_byte", {24'd0, tx_data}, {24'd0, e});
        end
      end
    end
  end

  // UART TX model: acknowledges a start with busy_len cycles of busy,
  // optionally ignoring starts, and checks the line is quiet while busy.
  initial begin
    logic [7:0] hold;
    logic       bad;
    logic       aborted;
    int         len;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) begin
        busy_m = 1'b0;
      end else if (tx_start) begin
        if (ignore_cnt > 0) begin
          ignore_cnt--;
        end else begin
          busy_m  = 1'b1;
          hold    = tx_data;
          bad     = 1'b0;
          aborted = 1'b0;
          len     = busy_len;
          repeat (len) begin
            @(posedge clk);
            #1;
            if (!rst_n) aborted = 1'b1;
            else if (tx_start || (tx_data !== hold)) bad = 1'b1;
          end
          busy_m = 1'b0;
          if (!aborted) chk("quiet_while_busy", {31'd0, bad}, 32'd0);
        end
      end
    end
  end

  task automatic issue(input logic [7:0] r, input logic c, input int resends);
    @(posedge clk);
    #1;
    dr = 1'b1;
    res = r;
    carry = c;
    for (int k = 0; k <= resends; k++) exp_q.push_back(8'hA5);
    exp_q.push_back(r);
    exp_q.push_back(flags_of(r, c));
    @(posedge clk);
    #1;
    dr = 1'b0;
    res = 8'($urandom);
    carry = 1'($urandom);
  endtask

  task automatic wait_idle(input string nm);
    int k;
    k = 0;
    while (busy && k < 600) begin
      @(negedge clk);
      k++;
    end
    chk(nm, {31'd0, busy}, 32'd0);
  endtask

  task automatic wait_starts(input string nm, input int target);
    int k;
    k = 0;
    while (start_cnt < target && k < 600) begin
      @(negedge clk);
      k++;
    end
    chk(nm, {31'd0, (start_cnt >= target)}, 32'd1);
  endtask

  initial begin
    int base;
    int n0;
    logic [7:0] r;

    // reset with random inputs
    rand_mode = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      dr = 1'($urandom);
      res = 8'($urandom);
      carry = 1'($urandom);
      rand_busy = 1'($urandom);
      @(negedge clk);
      chk("reset_outputs", {21'd0, tx_data, tx_start, busy, overrun}, 32'd0);
    end
    @(posedge clk);
    #1;
    dr = 1'b0;
    rand_mode = 1'b0;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_after_reset", {30'd0, busy, tx_start}, 32'd0);

    // 3C / carry 1 -> A5 3C 02
    base = start_cnt;
    issue(8'h3C, 1'b1, 0);
    wait_idle("frame_3c_done");
    chk("frame_3c_starts", start_cnt - base, 3);
    chk("frame_3c_drained", exp_q.size(), 0);

    // 00 / carry 0 -> A5 00 01
    base = start_cnt;
    issue(8'h00, 1'b0, 0);
    wait_idle("frame_00_done");
    chk("frame_00_starts", start_cnt - base, 3);
    chk("overrun_clear", {31'd0, overrun}, 32'd0);

    // request during byte 1 is dropped and flags overrun
    base = start_cnt;
    issue(8'h3C, 1'b1, 0);
    wait_starts("reach_byte1", base + 2);
    @(posedge clk);
    #1;
    dr = 1'b1;
    res = 8'hFF;
    @(posedge clk);
    #1;
    dr = 1'b0;
    @(negedge clk);
    chk("overrun_set", {31'd0, overrun}, 32'd1);
    wait_idle("frame_ovr_done");
    repeat (30) @(negedge clk);
    chk("frame_ovr_starts", start_cnt - base, 3);
    chk("overrun_sticky", {31'd0, overrun}, 32'd1);
    chk("frame_ovr_drained", exp_q.size(), 0);

    // TX ignores the first start -> header re-sent 16 cycles later
    base = start_cnt;
    n0 = start_times.size();
    ignore_cnt = 1;
    issue(8'h5A, 1'b0, 1);
    wait_idle("frame_resend_done");
    chk("frame_resend_starts", start_cnt - base, 4);
    if (start_times.size() >= n0 + 2)
      chk("resend_gap", start_times[n0+1] - start_times[n0], 16);
    else
      chk("resend_gap_present", start_times.size() - n0, 2);

    // random frames with random TX busy length
    for (int f = 0; f < 8; f++) begin
      busy_len = $urandom_range(1, 14);
      r = (f == 3) ? 8'h00 : 8'($urandom);
      base = start_cnt;
      issue(r, 1'($urandom), 0);
      wait_idle("rand_frame_done");
      chk("rand_frame_starts", start_cnt - base, 3);
    end
    busy_len = 10;
    chk("rand_drained", exp_q.size(), 0);
    chk("overrun_still_sticky", {31'd0, overrun}, 32'd1);

    // reset after byte 2 starts aborts the frame
    base = start_cnt;
    issue(8'h77, 1'b1, 0);
    wait_starts("reach_byte2", base + 3);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk("midframe_reset_outputs", {21'd0, tx_data, tx_start, busy, overrun}, 32'd0);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("no_resume", start_cnt - base, 3);
    base = start_cnt;
    issue(8'h11, 1'b0, 0);
    wait_idle("frame_11_done");
    chk("frame_11_starts", start_cnt - base, 3);
    chk("overrun_after_reset", {31'd0, overrun}, 32'd0);
    repeat (20) @(negedge clk);
    chk("final_drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, nbad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog");
  end

endmodule
